// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: state encoding and instruction geometry.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect arbitration: picks the jump or branch target and screens out
// targets that are not word aligned.
module next_pc_sel #(
    parameter int XLEN = 32
) (
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect_ok,
    output logic [XLEN-1:0] redirect_target,
    output logic            misaligned
);

    logic redirect;

    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        redirect        = branch_taken | jump_en;
        redirect_target = jump_en ? jump_target : branch_target;
        misaligned      = redirect && (redirect_target[1:0] != 2'b00);
        redirect_ok     = redirect && !misaligned;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem request/response
// handshake and holds one fetched instruction for decode.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            flush,
    output logic            misaligned_exc
);

    import riscv_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_target;
    logic            pend_valid;
    logic            redirect_ok;
    logic            misaligned;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            xfer;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .redirect_ok     (redirect_ok),
        .redirect_target (redirect_target),
        .misaligned      (misaligned)
    );

    // A request may only go out when its response is guaranteed a free buffer slot.
    assign xfer           = inst_valid && !stall;
    assign imem_req_valid = (state == REQ) && (!inst_valid || !stall);
    assign imem_addr      = (state == REQ) ? pc : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            pend_valid     <= 1'b0;
            pend_target    <= '0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            flush          <= 1'b0;
            misaligned_exc <= 1'b0;
        end else begin
            flush          <= redirect_ok;
            misaligned_exc <= misaligned;
            if (xfer || redirect_ok)
                inst_valid <= 1'b0;

            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_ok)
                        pc <= redirect_target;
                end
                REQ: begin
                    if (req_fire) begin
                        // The accepted address is already stale if any redirect has been seen.
                        pend_valid <= 1'b0;
                        if (redirect_ok) begin
                            pc    <= redirect_target;
                            state <= DROP;
                        end else if (pend_valid) begin
                            pc    <= pend_target;
                            state <= DROP;
                        end else begin
                            state <= RSP;
                        end
                    end else if (imem_req_valid) begin
                        if (redirect_ok) begin
                            pend_valid  <= 1'b1;
                            pend_target <= redirect_target;
                        end
                    end else begin
                        if (redirect_ok)
                            pc <= redirect_target;
                        else if (pend_valid)
                            pc <= pend_target;
                        pend_valid <= 1'b0;
                    end
                end
                RSP: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                        if (redirect_ok) begin
                            pc <= redirect_target;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + XLEN'(INST_BYTES);
                        end
                    end else if (redirect_ok) begin
                        pc    <= redirect_target;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_ok)
                        pc <= redirect_target;
                    if (imem_rsp_valid)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: instruction-stream scoreboard, memory
// responder with random ready/latency, and directed reset/stall/wrap checks.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = '0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush;
    logic        misaligned_exc;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .flush          (flush),
        .misaligned_exc (misaligned_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    typedef struct packed {
        logic flush;
        logic exc;
    } ev_t;

    inst_t       exp_q[$];
    ev_t         ev_q[$];
    logic [31:0] stream_pc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_xfer  = 0;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = '0;
    logic        prev_br = 1'b0;
    logic        prev_j  = 1'b0;
    logic [31:0] prev_bt = '0;
    logic [31:0] prev_jt = '0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The program the front end should deliver: sequential words from the
    // last accepted redirect target (or reset PC).
    task automatic top_up();
        inst_t it;
        while (exp_q.size() < 8) begin
            it.pc   = stream_pc;
            it.data = mem_fn(stream_pc);
            exp_q.push_back(it);
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        stream_pc = start;
        top_up();
    endtask

    // One clock of stimulus; first settles the model for last cycle's redirect.
    task automatic cycle(input logic br, input logic [31:0] bt, input logic j,
                         input logic [31:0] jt, input logic st);
        logic        redir;
        logic [31:0] tgt;
        ev_t         e;
        redir   = prev_br | prev_j;
        tgt     = prev_j ? prev_jt : prev_bt;
        e.flush = redir && (tgt[1:0] == 2'b00);
        e.exc   = redir && (tgt[1:0] != 2'b00);
        ev_q.push_back(e);
        if (e.flush)
            restart_stream(tgt);
        top_up();
        branch_taken  = br;
        branch_target = bt;
        jump_en       = j;
        jump_target   = jt;
        stall         = st;
        prev_br = br;
        prev_bt = bt;
        prev_j  = j;
        prev_jt = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 32'h0, 1'b0, 32'h0, st);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_misaligned_exc", misaligned_exc, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        jump_en       = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        stall         = 1'b0;
        prev_br = 1'b0;
        prev_j  = 1'b0;
        prev_bt = '0;
        prev_jt = '0;
        #1;
        check_reset_outputs();
        ev_q.delete();
        restart_stream(RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        int          r;
        r = $urandom_range(0, 99);
        t = 32'($urandom_range(0, 1023)) << 2;
        if (r < 10)
            t = 32'hFFFF_FFF0 + (t & 32'h0000_000C);
        if (r >= 85)
            t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    // Memory responder: one response per accepted request, after lat_min..lat_max cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                mem_cnt    = $urandom_range(lat_min, lat_max);
                mem_addr_q = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                mem_cnt = 0;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_fn(mem_addr_q);
                end
            end
            imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: per-cycle flush/exception expectations, delivered instructions, address hold.
    initial begin
        ev_t   e;
        inst_t it;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (ev_q.size() != 0) begin
                    e = ev_q.pop_front();
                    check("flush", flush, e.flush);
                    check("misaligned_exc", misaligned_exc, e.exc);
                end
                if (inst_valid && !stall) begin
                    n_xfer++;
                    check("xfer_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        it = exp_q.pop_front();
                        check("inst_pc", inst_pc, it.pc);
                        check("inst", inst, it.data);
                    end
                end
                if (hold_prev) begin
                    check("req_valid_hold", imem_req_valid, 1'b1);
                    check("req_addr_hold", imem_addr, hold_addr);
                end
                hold_prev = imem_req_valid && !imem_req_ready;
                hold_addr = imem_addr;
            end
        end
    end

    initial begin
        bit found;
        #2;
        do_reset();

        // First request follows the IDLE cycle.
        check("req_before_idle", imem_req_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_addr, RESET_PC);

        // Stalled buffer holds word 0 and blocks further requests.
        idle(6, 1'b1);
        check("stall_inst_valid", inst_valid, 1'b1);
        check("stall_inst_pc", inst_pc, RESET_PC);
        check("stall_inst", inst, mem_fn(RESET_PC));
        check("stall_no_req", imem_req_valid, 1'b0);
        stall = 1'b0;
        #1;
        check("drain_req_valid", imem_req_valid, 1'b1);
        check("drain_req_addr", imem_addr, RESET_PC + 32'd4);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(6, 1'b1);
        check("stall2_inst_pc", inst_pc, RESET_PC + 32'd4);
        check("stall2_no_req", imem_req_valid, 1'b0);
        idle(4, 1'b0);

        // Jump wins over branch; misaligned jump is ignored.
        cycle(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0300, 1'b0);
        idle(10, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0000_0302, 1'b0);
        idle(10, 1'b0);

        // Redirect while the request is refused by memory.
        ready_pct = 0;
        idle(3, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        idle(3, 1'b0);
        ready_pct = 100;
        idle(10, 1'b0);

        // Branch while a slow response is outstanding, then address wrap.
        lat_min = 3;
        lat_max = 3;
        idle(2, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        idle(12, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        idle(16, 1'b0);

        // Random traffic.
        ready_pct = 70;
        lat_min   = 1;
        lat_max   = 3;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) < 6, rand_tgt(), $urandom_range(0, 99) < 4,
                  rand_tgt(), $urandom_range(0, 99) < 25);
        ready_pct = 100;
        idle(20, 1'b0);

        // Reset while a response is outstanding.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            idle(1, 1'b0);
            #1;
            if (mem_cnt > 0)
                found = 1'b1;
        end
        check("rsp_wait", found, 1'b1);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        idle(20, 1'b0);

        check("progress", n_xfer > 100, 1'b1);
        check("stream_left", exp_q.size() != 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
